// File: rtl/alu_md.sv
// alu_md: execute-stage arithmetic unit for the pipelined MIPS datapath.
// A purely combinational ALU (result C plus eq/ltz branch flags) sits beside
// a multi-cycle multiply/divide engine that owns the architectural HI/LO
// registers and raises busy while an operation is in flight.
module alu_md #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUOp,
    output logic [WIDTH-1:0] C,
    output logic             eq,
    output logic             ltz,
    input  logic [2:0]       md_op,
    input  logic             start,
    output logic             busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int SHW  = $clog2(WIDTH);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [2:0] MD_MULT  = 3'b001;
    localparam logic [2:0] MD_MULTU = 3'b010;
    localparam logic [2:0] MD_DIV   = 3'b011;
    localparam logic [2:0] MD_DIVU  = 3'b100;
    localparam logic [2:0] MD_MTHI  = 3'b101;
    localparam logic [2:0] MD_MTLO  = 3'b110;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    // ------------------------------------------------------------------
    // Combinational ALU
    // ------------------------------------------------------------------
    logic [SHW-1:0] shamt;
    assign shamt = A[SHW-1:0];

    // ALU result selected by ALUOp; unused encodings produce zero.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        C = '0;
        case (ALUOp)
            4'b0000: C = A + B;
            4'b0001: C = A - B;
            4'b0010: C = A & B;
            4'b0011: C = A | B;
            4'b0100: C = A ^ B;
            4'b0101: C = ~(A | B);
            4'b0110: C = B << (WIDTH / 2);
            4'b0111: C = {{(WIDTH-1){1'b0}}, (A < B)};
            4'b1000: C = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            4'b1001: C = B << shamt;
            4'b1010: C = B >> shamt;
            4'b1011: C = $signed(B) >>> shamt;
            default: C = '0;
        endcase
    end

    assign eq  = (A == B);
    assign ltz = A[WIDTH-1];

    // ------------------------------------------------------------------
    // Multiply/divide engine
    // ------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       op_q;
    logic             load_ops;

    // Result datapath works only from the operands latched at start.
    logic [2*WIDTH-1:0] prod_s, prod_u;
    logic               sdiv, neg_q, neg_r;
    logic [WIDTH-1:0]   mag_a, mag_b, uquo, urem, quo, rem;
    logic [WIDTH-1:0]   res_hi, res_lo;

    assign prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
    assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

    // Signed division is done on magnitudes, then the signs are restored:
    // the quotient truncates toward zero and the remainder follows the
    // dividend. Most-negative / -1 falls out naturally as most-negative, 0.
    assign sdiv  = (op_q == MD_DIV);
    assign mag_a = (sdiv && a_q[WIDTH-1]) ? -a_q : a_q;
    assign mag_b = (sdiv && b_q[WIDTH-1]) ? -b_q : b_q;
    assign neg_q = sdiv && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
    assign neg_r = sdiv && a_q[WIDTH-1];

    // Unsigned divide of the magnitudes; the zero divisor is handled below.
    always_comb begin
        uquo = '0;
        urem = '0;
        if (mag_b != '0) begin
            uquo = mag_a / mag_b;
            urem = mag_a % mag_b;
        end
    end

    assign quo = neg_q ? -uquo : uquo;
    assign rem = neg_r ? -urem : urem;

    // Final HI/LO values for the latched operation.
    always_comb begin
        res_hi = hi_q;
        res_lo = lo_q;
        case (op_q)
            MD_MULT:  {res_hi, res_lo} = prod_s;
            MD_MULTU: {res_hi, res_lo} = prod_u;
            MD_DIV, MD_DIVU: begin
                if (b_q == '0) begin
                    res_lo = '1;
                    res_hi = a_q;
                end else begin
                    res_lo = quo;
                    res_hi = rem;
                end
            end
            default: ;
        endcase
    end

    // Engine next-state: accept work in IDLE, count down in RUN.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        load_ops = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (md_op)
                        MD_MULT, MD_MULTU: begin
                            load_ops = 1'b1;
                            cnt_d    = CW'(MULT_CYCLES);
                            busy_d   = 1'b1;
                            state_d  = S_RUN;
                        end
                        MD_DIV, MD_DIVU: begin
                            load_ops = 1'b1;
                            cnt_d    = CW'(DIV_CYCLES);
                            busy_d   = 1'b1;
                            state_d  = S_RUN;
                        end
                        MD_MTHI: hi_d = A;
                        MD_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                if (cnt_q == CW'(1)) begin
                    hi_d    = res_hi;
                    lo_d    = res_lo;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Engine registers with synchronous active-low reset that aborts any
    // in-flight operation.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            if (load_ops) begin
                a_q  <= A;
                b_q  <= B;
                op_q <= md_op;
            end
        end
    end

    assign busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: doc/alu_md.md
# alu_md

Parametrised execute-stage arithmetic unit for the pipelined MIPS datapath. It succeeds the single-cycle ALU with three additions: a wider opcode set, explicit comparison flags, and an integrated multi-cycle multiply/divide engine with architectural HI/LO registers. The combinational ALU result feeds the EX/MEM register. The multiply/divide engine runs independently and asserts `busy` so the hazard unit can stall HI/LO consumers.

## Interface
Parameters:
- `WIDTH`, 32: datapath width; must be even and ≥ 8.
- `MULT_CYCLES`, 5: cycles `busy` stays high for mult/multu; must be ≥ 1.
- `DIV_CYCLES`, 10: cycles `busy` stays high for div/divu; must be ≥ 1.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `A`  in  WIDTH  operand A (rs value).
- `B`  in  WIDTH  operand B (rt value or extended immediate).
- `ALUOp`  in  4  combinational ALU operation select.
- `C`  out  WIDTH  combinational ALU result.
- `eq`  out  1  A == B (beq/bne).
- `ltz`  out  1  A[WIDTH-1] (bgez/bltz/blez/bgtz use this together with `C`/`eq`).
- `md_op`  in  3  mult/div operation: 000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 none.
- `start`  in  1  qualifies `md_op` for one cycle.
- `busy`  out  1  registered; engine is computing.
- `HI`  out  WIDTH  registered HI.
- `LO`  out  WIDTH  registered LO.

## Operation
- ALU is purely combinational. It has no dependence on `clk` or `reset`.
- ALUOp encodings:
  - 0000: A+B.
  - 0001: A−B.
  - 0010: A&B.
  - 0011: A|B.
  - 0100: A^B.
  - 0101: ~(A|B).
  - 0110: B << (WIDTH/2) (lui).
  - 0111: unsigned A<B → 1, else 0 (sltu).
  - 1000: signed A<B → 1, else 0 (slt).
  - 1001: B << A[log2(WIDTH)-1:0].
  - 1010: logical shift right of B by the same amount.
  - 1011: arithmetic shift right of B by the same amount.
  - 1100–1111: C = 0.
- All arithmetic is modulo 2^WIDTH. There is no overflow flag.
- `eq` and `ltz` are always driven, independent of ALUOp.
- Engine states: IDLE, RUN. The counter is wide enough for max(MULT_CYCLES, DIV_CYCLES).
- IDLE with `start`=1 and md_op ∈ {mult, multu, div, divu}:
  - latch A, B, and the op;
  - load the counter with N (MULT_CYCLES or DIV_CYCLES);
  - set `busy`=1 and go to RUN.
- IDLE with `start`=1 and md_op = mthi: HI ← A on that edge, no busy. For mtlo: LO ← A, no busy.
- IDLE with `start`=1 and md_op none: no effect.
- RUN: the counter decrements each edge. On the edge where the counter equals 1:
  - write HI/LO;
  - set `busy`=0;
  - return to IDLE.
- RUN ignores `start` entirely (all md_op values, including mthi/mtlo). The hazard unit must not issue them while `busy`.
- Results use the latched operands, so changes on A/B during RUN have no effect.
  - mult: {HI,LO} = signed 2·WIDTH-bit product.
  - multu: {HI,LO} = unsigned 2·WIDTH-bit product.
  - div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - divu: LO = unsigned quotient; HI = unsigned remainder.
- Boundary results:
  - Divide by zero (div or divu): LO = all ones, HI = dividend. `busy` still lasts the full DIV_CYCLES.
  - div with most-negative ÷ −1: LO = most-negative, HI = 0.
- Reset (`reset`=0 at an edge) always wins:
  - HI=0, LO=0, `busy`=0, counter=0, state IDLE.
  - An in-flight operation is aborted with no HI/LO write.
  - Reset overrides a simultaneous `start`.

## Timing
- ALU outputs `C`, `eq`, `ltz`: zero latency, combinational.
- Reset values: `busy`=0, HI=0, LO=0. `C`, `eq`, `ltz` follow the inputs.
- Start accepted at edge T0. `busy` is high for cycles T0+1 through T0+N, exactly N cycles.
- HI/LO update at edge T0+N. New values are visible in the first cycle `busy` is low.
- Back-to-back operation: `start` in the cycle `busy` first reads 0 is accepted, giving no dead cycle.
- mthi/mtlo: HI/LO visible one cycle after the accepting edge.

## Test plan
- ALU sweep, WIDTH=32. Expected responses:
  - A=0x7FFFFFFF, B=1, ALUOp=0000 → C=0x80000000.
  - ALUOp=1000, A=0xFFFFFFFF, B=0 → C=1.
  - ALUOp=0111, same operands → C=0.
  - ALUOp=1011, A=4, B=0x80000000 → C=0xF8000000.
  - ALUOp=0110, B=0x1234 → C=0x12340000.
- mult: A=0xFFFFFFFE (−2), B=3, start → `busy` high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. multu with the same operands → HI=0x2, LO=0xFFFFFFFA.
- div: A=−7, B=2 → LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1), `busy` 10 cycles. divu A=7, B=0 → LO=0xFFFFFFFF, HI=7. div A=0x80000000, B=−1 → LO=0x80000000, HI=0.
- Busy protection: start mult, then pulse `start` with mtlo A=0xAAAA on the 2nd busy cycle → ignored; LO = product. Start divu on the first non-busy cycle → accepted immediately.
- Reset mid-operation: start div, drive `reset`=0 on the 3rd busy cycle → next cycle `busy`=0, HI=LO=0, and no later write occurs. `reset`=0 coincident with `start` → no operation begins.
- Parameter sweep: WIDTH=16, MULT_CYCLES=1, DIV_CYCLES=3. mult 0x8000×0x8000 → HI=0x4000, LO=0x0000 after 1 busy cycle. ALUOp=0110, B=0x00AB → C=0xAB00.
